sel_debounce: RTL and testbench

Conditions a raw, bouncy push-button input into a clean mode-select signal `sel` for the 4-bit up/down counter, which is directly downstream. The block synchronises the asynchronous button, debounces it with a per-transition stability counter under a four-state FSM, and emits a one-cycle press pulse. `sel` is either toggled per press or follows the debounced level (compile-time option). All outputs are registered, so the counter sees a glitch-free, clock-aligned `sel`.

---
 rtl/sel_debounce_pkg.sv | 14 +
 rtl/bit_sync.sv | 25 ++
 rtl/sel_debounce.sv | 120 ++++++++++++
 tb/tb_sel_debounce.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sel_debounce_pkg.sv
// Shared types and default constants for the sel_debounce push-button conditioner.
package sel_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO,
    CHK_HI,
    IDLE_HI,
    CHK_LO
  } db_state_t;

  localparam int unsigned DB_CYCLES_DEF   = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/bit_sync.sv
// N-flop synchroniser for a single asynchronous bit; all flops reset to 0.
module bit_sync
  import sel_debounce_pkg::*;
#(
  parameter int unsigned N = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[N-2:0], d};
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/sel_debounce.sv
// Push-button conditioner: synchroniser, four-state debounce FSM, press pulse and sel.
// Build option SEL_TOGGLE_EN: sel toggles per press; otherwise sel follows the debounced level.
module sel_debounce
  import sel_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter logic        SEL_INIT    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic stable,
  output logic btn_press,
  output logic sel
);

  localparam int unsigned      CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

`ifdef SEL_TOGGLE_EN
  localparam logic SEL_RST = SEL_INIT;
`else
  // In the level build sel mirrors stable, so it always comes out of reset low.
  localparam logic SEL_RST = SEL_INIT & 1'b0;
`endif

  logic             btn_s;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_d, press_d, sel_d;

  bit_sync #(.N(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (btn_s)
  );

  // Any sample disagreeing with the candidate level drops back to idle and clears the count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable;
    press_d  = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (btn_s) begin
          state_d = CHK_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CHK_HI: begin
        if (!btn_s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = IDLE_HI;
          stable_d = 1'b1;
          press_d  = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!btn_s) begin
          state_d = CHK_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CHK_LO: begin
        if (btn_s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = IDLE_LO;
          stable_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
`ifdef SEL_TOGGLE_EN
    sel_d = sel ^ press_d;
`else
    sel_d = stable_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE_LO;
      cnt_q     <= '0;
      stable    <= 1'b0;
      btn_press <= 1'b0;
      sel       <= SEL_RST;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stable    <= stable_d;
      btn_press <= press_d;
      sel       <= sel_d;
    end
  end

endmodule

// File: tb/tb_sel_debounce.sv
// Self-checking bench for sel_debounce against a run-length reference model of the debouncer.
module tb_sel_debounce;

  localparam int SYNC = 2;
  localparam int DB   = 16;
  localparam int LAT  = SYNC + DB - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw = 1'b0;
  logic stable, btn_press, sel;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: raw delay line plus a run length of samples that disagree with the level
  bit   sync_m[SYNC];
  bit   stable_m, press_m, sel_m;
  int   run_m;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  sel_debounce #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB), .SEL_INIT(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .stable    (stable),
    .btn_press (btn_press),
    .sel       (sel)
  );

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) sync_m[i] = 1'b0;
    stable_m = 1'b0;
    press_m  = 1'b0;
    sel_m    = 1'b0;
    run_m    = 0;
    exp_q.delete();
  endtask

  // Called at a falling edge; drives one raw sample, advances the model, returns at the next falling edge.
  task automatic step(input logic raw);
    bit s_prev;
    btn_raw = raw;
    @(posedge clk);
    #1;
    s_prev = sync_m[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) sync_m[i] = sync_m[i-1];
    sync_m[0] = raw;
    press_m = 1'b0;
    if (s_prev != stable_m) begin
      run_m++;
      if (run_m == DB) begin
        stable_m = s_prev;
        press_m  = s_prev;
        run_m    = 0;
      end
    end else begin
      run_m = 0;
    end
`ifdef SEL_TOGGLE_EN
    if (press_m) sel_m = ~sel_m;
`else
    sel_m = stable_m;
`endif
    exp_q.push_back({stable_m, press_m, sel_m});
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [2:0] e;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (stable !== 1'b0) begin n_fail++; $display("FAIL reset_stable got=%b exp=0", stable); end
    n_checks++;
    if (btn_press !== 1'b0) begin n_fail++; $display("FAIL reset_press got=%b exp=0", btn_press); end
    n_checks++;
    if (sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel got=%b exp=0", sel); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if ({stable, btn_press, sel} !== e) begin
        n_fail++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, {stable, btn_press, sel}, e);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] e;
    int presses = 0;
    int first_rise = -1;
    for (int i = 0; i < 30; i++) begin
      step(1'b1);
      e = exp_q.pop_front();
      n_checks++;
      if ({stable, btn_press, sel} !== e) begin
        n_fail++; $display("FAIL clean cyc=%0d got=%b exp=%b", i, {stable, btn_press, sel}, e);
      end
      if (btn_press) presses++;
      if (stable && first_rise < 0) first_rise = i;
    end
    n_checks++;
    if (presses != 1) begin n_fail++; $display("FAIL clean_press_count got=%0d exp=1", presses); end
    n_checks++;
    if (first_rise != LAT) begin n_fail++; $display("FAIL clean_latency got=%0d exp=%0d", first_rise, LAT); end
    n_checks++;
    if (sel !== 1'b1) begin n_fail++; $display("FAIL clean_sel got=%b exp=1", sel); end
  endtask

  task automatic test_release();
    logic [2:0] e;
    int presses = 0;
    int first_fall = -1;
    int sel_fall = -1;
    for (int i = 0; i < 30; i++) begin
      step(1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if ({stable, btn_press, sel} !== e) begin
        n_fail++; $display("FAIL release cyc=%0d got=%b exp=%b", i, {stable, btn_press, sel}, e);
      end
      if (btn_press) presses++;
      if (!stable && first_fall < 0) first_fall = i;
      if (!sel && sel_fall < 0) sel_fall = i;
    end
    n_checks++;
    if (presses != 0) begin n_fail++; $display("FAIL release_press_count got=%0d exp=0", presses); end
    n_checks++;
    if (first_fall != LAT) begin n_fail++; $display("FAIL release_latency got=%0d exp=%0d", first_fall, LAT); end
`ifndef SEL_TOGGLE_EN
    n_checks++;
    if (sel_fall != LAT) begin n_fail++; $display("FAIL release_sel_latency got=%0d exp=%0d", sel_fall, LAT); end
`endif
  endtask

  task automatic test_bounce();
    logic [2:0] e;
    int presses = 0;
    int press_at = -1;
    for (int i = 0; i < 60; i++) begin
      step(i < 20 ? (((i / 3) % 2) == 0) : 1'b1);
      e = exp_q.pop_front();
      n_checks++;
      if ({stable, btn_press, sel} !== e) begin
        n_fail++; $display("FAIL bounce cyc=%0d got=%b exp=%b", i, {stable, btn_press, sel}, e);
      end
      if (btn_press) begin presses++; press_at = i; end
    end
    n_checks++;
    if (presses != 1) begin n_fail++; $display("FAIL bounce_press_count got=%0d exp=1", presses); end
    n_checks++;
    if (press_at != 18 + LAT) begin n_fail++; $display("FAIL bounce_latency got=%0d exp=%0d", press_at, 18 + LAT); end
  endtask

  task automatic test_glitch();
    logic [2:0] e;
    logic sel_before;
    int changes = 0;
    sel_before = sel_m;
    for (int i = 0; i < 40; i++) begin
      step(i < 10);
      e = exp_q.pop_front();
      n_checks++;
      if ({stable, btn_press, sel} !== e) begin
        n_fail++; $display("FAIL glitch cyc=%0d got=%b exp=%b", i, {stable, btn_press, sel}, e);
      end
      if (stable || btn_press || sel !== sel_before) changes++;
    end
    n_checks++;
    if (changes != 0) begin n_fail++; $display("FAIL glitch_quiet got=%0d exp=0", changes); end
  endtask

  task automatic test_toggle_seq();
    logic [2:0] e;
    logic sel_exp;
    int hi_presses = 0;
    int lo_presses = 0;
`ifdef SEL_TOGGLE_EN
    sel_exp = ~sel_m;
`else
    sel_exp = 1'b0;
`endif
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 60; i++) begin
        step(i < 30);
        e = exp_q.pop_front();
        n_checks++;
        if ({stable, btn_press, sel} !== e) begin
          n_fail++; $display("FAIL toggle p=%0d cyc=%0d got=%b exp=%b", p, i, {stable, btn_press, sel}, e);
        end
        if (btn_press && i < 30) hi_presses++;
        if (btn_press && i >= 30) lo_presses++;
      end
    end
    n_checks++;
    if (hi_presses != 3) begin n_fail++; $display("FAIL toggle_presses got=%0d exp=3", hi_presses); end
    n_checks++;
    if (lo_presses != 0) begin n_fail++; $display("FAIL toggle_release_press got=%0d exp=0", lo_presses); end
    n_checks++;
    if (sel !== sel_exp) begin n_fail++; $display("FAIL toggle_final_sel got=%b exp=%b", sel, sel_exp); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    int presses = 0;
    int press_at = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      e = exp_q.pop_front();
      n_checks++;
      if ({stable, btn_press, sel} !== e) begin
        n_fail++; $display("FAIL rmid_pre cyc=%0d got=%b exp=%b", i, {stable, btn_press, sel}, e);
      end
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({stable, btn_press, sel} !== 3'b000) begin
      n_fail++; $display("FAIL rmid_reset got=%b exp=000", {stable, btn_press, sel});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1'b1);
      e = exp_q.pop_front();
      n_checks++;
      if ({stable, btn_press, sel} !== e) begin
        n_fail++; $display("FAIL rmid_post cyc=%0d got=%b exp=%b", i, {stable, btn_press, sel}, e);
      end
      if (btn_press) begin presses++; press_at = i; end
    end
    n_checks++;
    if (presses != 1 || press_at != LAT) begin
      n_fail++; $display("FAIL rmid_press got=%0d@%0d exp=1@%0d", presses, press_at, LAT);
    end
  endtask

  task automatic test_random();
    logic [2:0] e;
    logic lvl;
    int len;
    for (int s = 0; s < 40; s++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        step(lvl);
        e = exp_q.pop_front();
        n_checks++;
        if ({stable, btn_press, sel} !== e) begin
          n_fail++; $display("FAIL random seg=%0d cyc=%0d got=%b exp=%b", s, i, {stable, btn_press, sel}, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_release();
    test_glitch();
    test_toggle_seq();
    test_reset_mid();
    test_release();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
